// File: rtl/img_addr_gen.sv
// img_addr_gen: 2-D SRAM address walker for streaming one image frame.
// Ports: start/abort control, cfg_* frame geometry (latched on start),
//   advance handshake in; addr/col/row, addr_valid, row_end,
//   frame_done, cfg_err and busy status out.
module img_addr_gen #(
    parameter int COL_BITS  = 13,
    parameter int ROW_BITS  = 13,
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [COL_BITS-1:0]  cfg_width,
    input  logic [ROW_BITS-1:0]  cfg_height,
    input  logic [ADDR_BITS-1:0] cfg_base,
    input  logic [ADDR_BITS-1:0] cfg_stride,
    input  logic                 advance,
    output logic [ADDR_BITS-1:0] addr,
    output logic [COL_BITS-1:0]  col,
    output logic [ROW_BITS-1:0]  row,
    output logic                 addr_valid,
    output logic                 row_end,
    output logic                 frame_done,
    output logic                 cfg_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [COL_BITS-1:0]  COL_ONE  = 1;
    localparam logic [ROW_BITS-1:0]  ROW_ONE  = 1;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

    state_t               state_q, state_d;
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] rbase_q, rbase_d;
    logic [COL_BITS-1:0]  width_q, width_d;
    logic [ROW_BITS-1:0]  height_q, height_d;
    logic [ADDR_BITS-1:0] stride_q, stride_d;
    logic                 cerr_q, cerr_d;

    logic last_col;
    logic last_row;

    assign last_col = (col_q == width_q - COL_ONE);
    assign last_row = (row_q == height_q - ROW_ONE);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        rbase_d  = rbase_q;
        width_d  = width_q;
        height_d = height_q;
        stride_d = stride_q;
        cerr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort is a no-op here, so a start alongside it still runs
                if (start) begin
                    if (cfg_width == '0 || cfg_height == '0) begin
                        cerr_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        width_d  = cfg_width;
                        height_d = cfg_height;
                        stride_d = cfg_stride;
                        rbase_d  = cfg_base;
                        addr_d   = cfg_base;
                        col_d    = '0;
                        row_d    = '0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    rbase_d = '0;
                end else if (advance) begin
                    if (!last_col) begin
                        col_d  = col_q + COL_ONE;
                        addr_d = addr_q + ADDR_ONE;
                    end else if (!last_row) begin
                        // row wrap: next address comes from the row base,
                        // not from addr, so stride < width is harmless
                        col_d   = '0;
                        row_d   = row_q + ROW_ONE;
                        rbase_d = rbase_q + stride_q;
                        addr_d  = rbase_q + stride_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
                addr_d  = '0;
                rbase_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            rbase_q  <= '0;
            width_q  <= '0;
            height_q <= '0;
            stride_q <= '0;
            cerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            rbase_q  <= rbase_d;
            width_q  <= width_d;
            height_q <= height_d;
            stride_q <= stride_d;
            cerr_q   <= cerr_d;
        end
    end

    assign addr       = addr_q;
    assign col        = col_q;
    assign row        = row_q;
    assign addr_valid = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign cfg_err    = cerr_q;
    assign row_end    = addr_valid & last_col;

endmodule

// File: tb/tb_img_addr_gen.sv
// tb_img_addr_gen: directed scoreboard bench for img_addr_gen.
// Expected outputs are queued per driven cycle and checked after each edge.
module tb_img_addr_gen;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic        abort;
    logic [12:0] cfg_width;
    logic [12:0] cfg_height;
    logic [23:0] cfg_base;
    logic [23:0] cfg_stride;
    logic        advance;
    logic [23:0] addr;
    logic [12:0] col;
    logic [12:0] row;
    logic        addr_valid;
    logic        row_end;
    logic        frame_done;
    logic        cfg_err;
    logic        busy;

    int checks;
    int errors;

    typedef struct {
        logic        v;
        logic        re;
        logic        fd;
        logic        ce;
        logic        bz;
        logic        pos;
        logic [23:0] a;
        logic [12:0] c;
        logic [12:0] r;
    } exp_t;

    exp_t sb[$];

    img_addr_gen dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_base   (cfg_base),
        .cfg_stride (cfg_stride),
        .advance    (advance),
        .addr       (addr),
        .col        (col),
        .row        (row),
        .addr_valid (addr_valid),
        .row_end    (row_end),
        .frame_done (frame_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t e_idle();
        exp_t e;
        e.v = 0; e.re = 0; e.fd = 0; e.ce = 0; e.bz = 0;
        e.pos = 1; e.a = '0; e.c = '0; e.r = '0;
        return e;
    endfunction

    function automatic exp_t e_run(input int c, input int r,
                                   input logic [23:0] a, input logic re);
        exp_t e;
        e = e_idle();
        e.v  = 1;
        e.bz = 1;
        e.re = re;
        e.a  = a;
        e.c  = 13'(c);
        e.r  = 13'(r);
        return e;
    endfunction

    function automatic exp_t e_done();
        exp_t e;
        e = e_idle();
        e.fd  = 1;
        e.bz  = 1;
        e.pos = 0;
        return e;
    endfunction

    function automatic exp_t e_cerr();
        exp_t e;
        e = e_idle();
        e.ce = 1;
        return e;
    endfunction

    function automatic logic [23:0] pa(input logic [23:0] b,
                                       input logic [23:0] s,
                                       input int r, input int c);
        return 24'(b + s * 24'(r) + 24'(c));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("addr_valid", 32'(addr_valid), 32'(e.v));
        chk("row_end", 32'(row_end), 32'(e.re));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("cfg_err", 32'(cfg_err), 32'(e.ce));
        chk("busy", 32'(busy), 32'(e.bz));
        if (e.pos) begin
            chk("addr", 32'(addr), 32'(e.a));
            chk("col", 32'(col), 32'(e.c));
            chk("row", 32'(row), 32'(e.r));
        end
    endtask

    task automatic step(input logic s, input logic ab, input logic adv,
                        input logic rst, input exp_t e);
        start   = s;
        abort   = ab;
        advance = adv;
        n_rst   = rst;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out(sb.pop_front());
    endtask

    task automatic set_cfg(input int w, input int h,
                           input logic [23:0] b, input logic [23:0] s);
        cfg_width  = 13'(w);
        cfg_height = 13'(h);
        cfg_base   = b;
        cfg_stride = s;
    endtask

    // Full frame; tog inserts an advance=0 cycle before every accept.
    task automatic frame(input int w, input int h, input logic [23:0] b,
                         input logic [23:0] s, input bit tog,
                         input bit ab0);
        exp_t nxt;
        int   nc;
        int   nr;
        set_cfg(w, h, b, s);
        step(1, ab0, 0, 1, e_run(0, 0, b, w == 1));
        // cfg changes after the start cycle must not matter
        set_cfg(w + 3, h + 1, ~b, s + 24'd5);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (tog)
                    step(0, 0, 0, 1, e_run(c, r, pa(b, s, r, c), c == w - 1));
                if (c == w - 1 && r == h - 1) begin
                    nxt = e_done();
                end else begin
                    nc  = (c == w - 1) ? 0 : c + 1;
                    nr  = (c == w - 1) ? r + 1 : r;
                    nxt = e_run(nc, nr, pa(b, s, nr, nc), nc == w - 1);
                end
                step(0, 0, 1, 1, nxt);
            end
        end
        step(0, 0, 0, 1, e_idle());
    endtask

    // Start a frame and accept n pixels, leaving it mid-RUN.
    task automatic partial(input int w, input int h, input logic [23:0] b,
                           input logic [23:0] s, input int n);
        int c;
        int r;
        set_cfg(w, h, b, s);
        step(1, 0, 0, 1, e_run(0, 0, b, w == 1));
        for (int k = 1; k <= n; k++) begin
            c = k % w;
            r = k / w;
            step(0, 0, 1, 1, e_run(c, r, pa(b, s, r, c), c == w - 1));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_rst = 0; start = 0; abort = 0; advance = 0;
        set_cfg(0, 0, 24'h0, 24'h0);

        step(0, 0, 0, 0, e_idle());
        step(0, 0, 0, 0, e_idle());
        step(0, 0, 0, 1, e_idle());

        frame(4, 3, 24'h100, 24'h8, 0, 0);
        frame(4, 3, 24'h100, 24'h8, 1, 0);

        set_cfg(0, 3, 24'h100, 24'h8);
        step(1, 0, 0, 1, e_cerr());
        step(0, 0, 0, 1, e_idle());
        set_cfg(4, 0, 24'h100, 24'h8);
        step(1, 0, 0, 1, e_cerr());
        step(0, 0, 0, 1, e_idle());

        frame(1, 1, 24'h55, 24'h3, 0, 0);
        frame(8191, 2, 24'hFFFFFF, 24'h2000, 0, 0);

        partial(4, 3, 24'h100, 24'h8, 2);
        step(0, 0, 1, 0, e_idle());
        step(0, 0, 0, 1, e_idle());

        partial(4, 3, 24'h200, 24'h10, 6);
        step(0, 1, 1, 1, e_idle());
        frame(4, 3, 24'h300, 24'h8, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
